serv_bus_arbiter: RTL and testbench

//  Shares the single Wishbone core bus (core_cyc/stb/we/addr/data/ack) between the SERV instruction bus and data bus.

---
 rtl/serv_bus_pkg.sv | 20 ++
 rtl/wb_timeout_counter.sv | 39 +++
 rtl/serv_bus_arbiter.sv | 178 +++++++++++++++++
 tb/tb_serv_bus_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serv_bus_pkg.sv
// serv_bus_pkg: shared types and constants for the SERV core-bus arbiter.
// Imported by serv_bus_arbiter.
package serv_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUS_I,
    BUS_D,
    RESP
  } arb_state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_e;

  localparam logic [3:0]  WB_SEL_ALL       = 4'hF;
  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_timeout_counter.sv
// wb_timeout_counter: counts bus cycles without a slave ack.
// o_expired flags the last allowed cycle; 0 cycles disables it.
module wb_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic w_unused;
      assign w_unused  = ^{clk, rst_n, i_clear, i_en};
      assign o_expired = 1'b0;
    end else begin : g_on
      localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

      logic [W-1:0] r_cnt;

      // Count while the bus is owned; saturate on the last cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (i_clear) begin
          r_cnt <= '0;
        end else if (i_en && (r_cnt != LAST)) begin
          r_cnt <= r_cnt + W'(1);
        end
      end

      assign o_expired = i_en && (r_cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/serv_bus_arbiter.sv
// serv_bus_arbiter: shares one Wishbone core bus between SERV ibus/dbus.
// One registered grant at a time; owner gets a registered 1-cycle ack.
module serv_bus_arbiter
  import serv_bus_pkg::*;
#(
  parameter string       PRIORITY       = "DATA",
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = DEFAULT_ERR_DATA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  output logic        core_cyc,
  output logic        core_stb,
  output logic        core_we,
  output logic [31:0] core_addr,
  output logic [31:0] core_data_out,
  output logic [3:0]  core_sel,
  input  logic [31:0] core_data_in,
  input  logic        core_ack,
  output logic        o_timeout
);

  localparam bit P_RR = (PRIORITY == "RR");

  arb_state_e  r_state, w_state_n;
  owner_e      r_last, w_last_n;
  logic        r_cyc, w_cyc_n;
  logic        r_we, w_we_n;
  logic [31:0] r_adr, w_adr_n;
  logic [31:0] r_dat, w_dat_n;
  logic [3:0]  r_sel, w_sel_n;
  logic [31:0] r_irdt, w_irdt_n;
  logic [31:0] r_drdt, w_drdt_n;
  logic        r_iack, w_iack_n;
  logic        r_dack, w_dack_n;
  logic        r_timeout, w_to_n;
  logic [31:0] w_rdt;

  logic w_in_bus;
  logic w_own_d;
  logic w_own_cyc;
  logic w_pick_d;
  logic w_expired;

  assign w_in_bus  = (r_state == BUS_I) || (r_state == BUS_D);
  assign w_own_d   = (r_state == BUS_D);
  assign w_own_cyc = w_own_d ? i_dbus_cyc : i_ibus_cyc;
  assign w_pick_d  = i_dbus_cyc &&
                     (!i_ibus_cyc || !P_RR || (r_last == OWN_I));

  wb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (!w_in_bus),
    .i_en     (w_in_bus),
    .o_expired(w_expired)
  );

  // Next-state and next-register values for the arbiter FSM.
  always_comb begin
    w_state_n = r_state;
    w_last_n  = r_last;
    w_cyc_n   = r_cyc;
    w_we_n    = r_we;
    w_adr_n   = r_adr;
    w_dat_n   = r_dat;
    w_sel_n   = r_sel;
    w_irdt_n  = r_irdt;
    w_drdt_n  = r_drdt;
    w_iack_n  = 1'b0;
    w_dack_n  = 1'b0;
    w_to_n    = r_timeout;
    w_rdt     = '0;
    unique case (r_state)
      IDLE: begin
        if (w_pick_d) begin
          w_state_n = BUS_D;
          w_last_n  = OWN_D;
          w_cyc_n   = 1'b1;
          w_we_n    = i_dbus_we;
          w_adr_n   = i_dbus_adr;
          w_dat_n   = i_dbus_dat;
          w_sel_n   = i_dbus_sel;
        end else if (i_ibus_cyc) begin
          w_state_n = BUS_I;
          w_last_n  = OWN_I;
          w_cyc_n   = 1'b1;
          w_we_n    = 1'b0;
          w_adr_n   = i_ibus_adr;
          w_dat_n   = '0;
          w_sel_n   = WB_SEL_ALL;
        end
      end
      BUS_I, BUS_D: begin
        if (!w_own_cyc) begin
          w_state_n = IDLE;
          w_cyc_n   = 1'b0;
        end else if (core_ack || w_expired) begin
          w_state_n = RESP;
          w_cyc_n   = 1'b0;
          w_rdt     = core_ack ? core_data_in : ERR_DATA;
          w_to_n    = r_timeout | ~core_ack;
          if (w_own_d) begin
            w_drdt_n = w_rdt;
            w_dack_n = 1'b1;
          end else begin
            w_irdt_n = w_rdt;
            w_iack_n = 1'b1;
          end
        end
      end
      RESP: begin
        w_state_n = IDLE;
      end
      default: begin
        w_state_n = IDLE;
        w_cyc_n   = 1'b0;
      end
    endcase
  end

  // State and output registers; every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_last    <= OWN_I;
      r_cyc     <= 1'b0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_sel     <= '0;
      r_irdt    <= '0;
      r_drdt    <= '0;
      r_iack    <= 1'b0;
      r_dack    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_last    <= w_last_n;
      r_cyc     <= w_cyc_n;
      r_we      <= w_we_n;
      r_adr     <= w_adr_n;
      r_dat     <= w_dat_n;
      r_sel     <= w_sel_n;
      r_irdt    <= w_irdt_n;
      r_drdt    <= w_drdt_n;
      r_iack    <= w_iack_n;
      r_dack    <= w_dack_n;
      r_timeout <= w_to_n;
    end
  end

  assign core_cyc      = r_cyc;
  assign core_stb      = r_cyc;
  assign core_we       = r_we;
  assign core_addr     = r_adr;
  assign core_data_out = r_dat;
  assign core_sel      = r_sel;
  assign o_ibus_rdt    = r_irdt;
  assign o_ibus_ack    = r_iack;
  assign o_dbus_rdt    = r_drdt;
  assign o_dbus_ack    = r_dack;
  assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_serv_bus_arbiter.sv
// tb_serv_bus_arbiter: scoreboard bench for serv_bus_arbiter.
// DUT a: DATA priority; DUT b: round-robin; both time out after 8.
module tb_serv_bus_arbiter;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] ia_adr = '0, da_adr = '0, da_dat = '0, ca_din = '0;
  logic        ia_cyc = 0, da_cyc = 0, da_we = 0, ca_ack = 0;
  logic [3:0]  da_sel = '0;
  logic [31:0] ca_irdt, ca_drdt, ca_addr, ca_dout;
  logic        ca_iack, ca_dack, ca_cyc, ca_stb, ca_we, ca_to;
  logic [3:0]  ca_sel;

  logic [31:0] b_din = '0;
  logic        b_icyc = 0, b_dcyc = 0, b_ack = 0;
  logic [31:0] cb_irdt, cb_drdt, cb_addr, cb_dout;
  logic        cb_iack, cb_dack, cb_cyc, cb_stb, cb_we, cb_to;
  logic [3:0]  cb_sel;

  serv_bus_arbiter #(
    .PRIORITY("DATA"), .TIMEOUT_CYCLES(TO)
  ) u_a (
    .clk(clk), .rst_n(rst_n),
    .i_ibus_adr(ia_adr), .i_ibus_cyc(ia_cyc),
    .o_ibus_rdt(ca_irdt), .o_ibus_ack(ca_iack),
    .i_dbus_adr(da_adr), .i_dbus_dat(da_dat), .i_dbus_sel(da_sel),
    .i_dbus_we(da_we), .i_dbus_cyc(da_cyc),
    .o_dbus_rdt(ca_drdt), .o_dbus_ack(ca_dack),
    .core_cyc(ca_cyc), .core_stb(ca_stb), .core_we(ca_we),
    .core_addr(ca_addr), .core_data_out(ca_dout), .core_sel(ca_sel),
    .core_data_in(ca_din), .core_ack(ca_ack), .o_timeout(ca_to)
  );

  serv_bus_arbiter #(
    .PRIORITY("RR"), .TIMEOUT_CYCLES(TO)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .i_ibus_adr(32'h100), .i_ibus_cyc(b_icyc),
    .o_ibus_rdt(cb_irdt), .o_ibus_ack(cb_iack),
    .i_dbus_adr(32'h200), .i_dbus_dat(32'h0), .i_dbus_sel(4'hF),
    .i_dbus_we(1'b0), .i_dbus_cyc(b_dcyc),
    .o_dbus_rdt(cb_drdt), .o_dbus_ack(cb_dack),
    .core_cyc(cb_cyc), .core_stb(cb_stb), .core_we(cb_we),
    .core_addr(cb_addr), .core_data_out(cb_dout), .core_sel(cb_sel),
    .core_data_in(b_din), .core_ack(b_ack), .o_timeout(cb_to)
  );

  typedef struct {
    bit          own_d;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    bit          we;
    logic [31:0] rdt;
    int          lat;
  } exp_t;

  exp_t        q[$];
  logic [31:0] qb[$];

  int total = 0;
  int bad = 0;

  int n_iack = 0, n_dack = 0, nb_i = 0, nb_d = 0;
  int low_run = 0, last_gap = 0;

  // Observe ack pulses and idle gaps on the core bus.
  always @(negedge clk) begin
    if (ca_cyc) begin
      if (low_run > 0) last_gap <= low_run;
      low_run <= 0;
    end else begin
      low_run <= low_run + 1;
    end
    if (ca_iack) n_iack <= n_iack + 1;
    if (ca_dack) n_dack <= n_dack + 1;
    if (cb_iack) nb_i <= nb_i + 1;
    if (cb_dack) nb_d <= nb_d + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input bit own_d, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel,
                      input bit we, input logic [31:0] rdt,
                      input int lat);
    exp_t e;
    e.own_d = own_d; e.adr = adr; e.dat = dat; e.sel = sel;
    e.we = we; e.rdt = rdt; e.lat = lat;
    q.push_back(e);
  endtask

  task automatic fields(input exp_t e);
    check("stb", ca_stb, 1);
    check("addr", ca_addr, e.adr);
    check("we", ca_we, e.we);
    check("sel", ca_sel, e.sel);
    check("dout", ca_dout, e.dat);
  endtask

  // Serve the next expected grant on DUT a; dly<0 means never ack.
  task automatic serve(input int dly);
    exp_t e;
    int n;
    if (q.size() == 0) begin
      check("q_empty", 1, 0);
      return;
    end
    e = q.pop_front();
    n = 0;
    do begin @(negedge clk); n++; end while (!ca_cyc && n < 40);
    check("grant", ca_cyc, 1);
    if (!ca_cyc) return;
    if (e.lat != 0) check("lat", n, e.lat);
    fields(e);
    if (dly < 0) begin
      n = 1;
      while (ca_cyc && n < 40) begin
        @(negedge clk);
        if (ca_cyc) n++;
      end
      check("to_len", n, TO);
    end else begin
      for (int i = 1; i < dly; i++) begin
        @(negedge clk);
        fields(e);
      end
      @(posedge clk); #1;
      ca_ack = 1; ca_din = e.rdt;
      @(negedge clk);
      fields(e);
      @(posedge clk); #1;
      ca_ack = 0;
      @(negedge clk);
    end
    check("cyc_off", ca_cyc, 0);
    check("own_ack", e.own_d ? ca_dack : ca_iack, 1);
    check("oth_ack", e.own_d ? ca_iack : ca_dack, 0);
    check("rdt", e.own_d ? ca_drdt : ca_irdt, e.rdt);
    @(posedge clk); #1;
    if (e.own_d) da_cyc = 0;
    else ia_cyc = 0;
    @(negedge clk);
    check("ack_1cyc", ca_iack | ca_dack, 0);
  endtask

  task automatic req_i(input logic [31:0] adr);
    @(posedge clk); #1;
    ia_cyc = 1; ia_adr = adr;
  endtask

  task automatic req_d(input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input bit we);
    @(posedge clk); #1;
    da_cyc = 1; da_adr = adr; da_dat = dat; da_sel = sel; da_we = we;
  endtask

  int ni0, nd0, n;

  initial begin
    #2 rst_n = 0;
    #1;
    check("rst_ctl_a", {ca_cyc, ca_stb, ca_iack, ca_dack, ca_to}, 0);
    check("rst_ctl_b", {cb_cyc, cb_iack, cb_dack, cb_to}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;

    // read on ibus
    ni0 = n_iack; nd0 = n_dack;
    req_i(32'h100);
    push(0, 32'h100, 32'h0, 4'hF, 0, 32'h13, 2);
    serve(1);
    check("rd_iack_n", n_iack - ni0, 1);
    check("rd_dack_n", n_dack - nd0, 0);

    // write on dbus
    ni0 = n_iack; nd0 = n_dack;
    req_d(32'h2000, 32'hCAFE_F00D, 4'b0011, 1);
    push(1, 32'h2000, 32'hCAFE_F00D, 4'b0011, 1, 32'h1111_2222, 2);
    serve(2);
    check("wr_dack_n", n_dack - nd0, 1);
    check("wr_iack_n", n_iack - ni0, 0);

    // tie with DATA priority
    @(posedge clk); #1;
    ia_cyc = 1; ia_adr = 32'h300;
    da_cyc = 1; da_adr = 32'h400; da_dat = 0; da_sel = 4'hF; da_we = 0;
    push(1, 32'h400, 32'h0, 4'hF, 0, 32'hAAAA_0001, 2);
    push(0, 32'h300, 32'h0, 4'hF, 0, 32'hBBBB_0002, 0);
    serve(1);
    serve(1);
    check("tie_gap", last_gap >= 2, 1);

    // round-robin ties on DUT b
    qb.push_back(32'h200); qb.push_back(32'h100);
    qb.push_back(32'h200); qb.push_back(32'h100);
    @(posedge clk); #1;
    b_icyc = 1; b_dcyc = 1;
    repeat (4) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!cb_cyc && n < 20);
      check("rr_seen", cb_cyc, 1);
      check("rr_owner", cb_addr, qb.pop_front());
      @(posedge clk); #1;
      b_ack = 1; b_din = 32'h42;
      @(posedge clk); #1;
      b_ack = 0;
    end
    b_icyc = 0; b_dcyc = 0;
    repeat (4) @(negedge clk);
    check("rr_iack_n", nb_i, 2);
    check("rr_dack_n", nb_d, 2);
    check("rr_cyc_idle", cb_cyc, 0);

    // timeout
    check("to_before", ca_to, 0);
    req_d(32'h500, 32'h0, 4'hF, 0);
    push(1, 32'h500, 32'h0, 4'hF, 0, 32'hDEAD_BEEF, 2);
    serve(-1);
    check("to_set", ca_to, 1);
    req_i(32'h104);
    push(0, 32'h104, 32'h0, 4'hF, 0, 32'h55, 2);
    serve(2);
    check("to_sticky", ca_to, 1);

    // abort: owner drops cyc, simultaneous ack ignored
    nd0 = n_dack;
    req_d(32'h600, 32'h0, 4'hF, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!ca_cyc && n < 20);
    check("ab_grant", ca_cyc, 1);
    @(posedge clk); #1;
    da_cyc = 0; ca_ack = 1; ca_din = 32'h77;
    @(negedge clk);
    @(posedge clk); #1;
    ca_ack = 0;
    @(negedge clk);
    check("ab_cyc", ca_cyc, 0);
    check("ab_ack", ca_dack, 0);
    check("ab_rdt", ca_drdt, 32'hDEAD_BEEF);
    repeat (3) @(negedge clk);
    check("ab_ack_n", n_dack - nd0, 0);

    // asynchronous reset mid-transfer
    req_i(32'h700);
    n = 0;
    do begin @(negedge clk); n++; end while (!ca_cyc && n < 20);
    check("rs_grant", ca_cyc, 1);
    #2 rst_n = 0;
    #1;
    check("rs_ctl", {ca_cyc, ca_stb, ca_we, ca_sel, ca_iack,
                     ca_dack, ca_to}, 0);
    check("rs_addr", ca_addr, 0);
    check("rs_dout", ca_dout, 0);
    check("rs_irdt", ca_irdt, 0);
    check("rs_drdt", ca_drdt, 0);
    check("rs_b_rdt", cb_irdt | cb_drdt, 0);
    ia_cyc = 0;
    @(negedge clk);
    rst_n = 1;

    // recovery after reset
    req_i(32'h800);
    push(0, 32'h800, 32'h0, 4'hF, 0, 32'h99, 2);
    serve(1);
    check("rs_to_clr", ca_to, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
